// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter.
//   state_t   : sequencer states (IDLE, ACCESS, WAIT)
//   port_id_t : requester index (PORT_FETCH = instruction fetch, PORT_DATA = load/store)
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2
  } state_t;

  typedef logic port_id_t;

  localparam port_id_t PORT_FETCH = 1'b0;
  localparam port_id_t PORT_DATA  = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input combinational grant logic.
//   req[1:0]   : request vector (bit N = port N valid)
//   last_grant : port granted by the previous handshake
//   enable     : grants are only issued while asserted
//   gnt[1:0]   : one-hot grant, all-zero when disabled or nothing requested
// Build option: MEM_ARB_FIXED_PRIO_EN selects fixed priority (port 0 wins
// every tie, port 1 may starve); otherwise ties alternate round-robin.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  port_id_t   last_grant,
  input  logic       enable,
  output logic [1:0] gnt
);

`ifdef MEM_ARB_FIXED_PRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  always_comb begin
    gnt = 2'b00;
    if (enable) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
`ifdef MEM_ARB_FIXED_PRIO_EN
        2'b11:   gnt = 2'b01;
`else
        // Tie goes to whichever port did not win last time.
        2'b11:   gnt = (last_grant == PORT_FETCH) ? 2'b10 : 2'b01;
`endif
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter/sequencer in front of a single-port memory.
// Port 0 = instruction fetch, port 1 = load/store. One transaction at a
// time: IDLE (arbitrate/handshake) -> ACCESS -> [WAIT for reads] -> IDLE.
// Ports:
//   clk, reset                   : clock, async active-high reset
//   reqN_valid/ready/write/addr/wdata : request handshake for port N
//   rspN_valid/rdata             : one-cycle response pulse + read data (0 on write ack)
//   mem_write/read/address/data_in/data_out : memory interface
//   busy                         : high whenever not IDLE
// Build option: MEM_ARB_FIXED_PRIO_EN (see rr_arbiter2).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic                 req0_write,
  input  logic [WIDTH-1:0]     req0_addr,
  input  logic [2*WIDTH-1:0]   req0_wdata,
  output logic                 rsp0_valid,
  output logic [2*WIDTH-1:0]   rsp0_rdata,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic                 req1_write,
  input  logic [WIDTH-1:0]     req1_addr,
  input  logic [2*WIDTH-1:0]   req1_wdata,
  output logic                 rsp1_valid,
  output logic [2*WIDTH-1:0]   rsp1_rdata,
  output logic                 mem_write,
  output logic                 mem_read,
  output logic [WIDTH-1:0]     mem_address,
  output logic [2*WIDTH-1:0]   mem_data_in,
  input  logic [2*WIDTH-1:0]   mem_data_out,
  output logic                 busy
);

  localparam int DW = 2 * WIDTH;

  state_t           state, state_nxt;
  port_id_t         last_grant, port_q, win_port;
  logic             wr_q;
  logic [WIDTH-1:0] addr_q;
  logic [DW-1:0]    wdata_q;
  logic [1:0]       gnt;
  logic             hs, done;
  logic             rsp_vld_q;
  logic [DW-1:0]    rdata0_q, rdata1_q;

  rr_arbiter2 u_arb (
    .req        ({req1_valid, req0_valid}),
    .last_grant (last_grant),
    .enable     (state == IDLE),
    .gnt        (gnt)
  );

  // gnt is already qualified by valid and IDLE, so any grant is a handshake.
  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  assign hs         = |gnt;
  assign win_port   = gnt[1] ? PORT_DATA : PORT_FETCH;

  // Transaction finishes at the end of a write ACCESS or of a read WAIT.
  assign done = ((state == ACCESS) && wr_q) || (state == WAIT);

  always_comb begin
    state_nxt   = state;
    mem_write   = 1'b0;
    mem_read    = 1'b0;
    mem_address = '0;
    mem_data_in = '0;
    case (state)
      IDLE: begin
        if (hs) state_nxt = ACCESS;
      end
      ACCESS: begin
        mem_address = addr_q;
        mem_data_in = wdata_q;
        if (wr_q) begin
          mem_write = 1'b1;
          state_nxt = IDLE;
        end else begin
          mem_read  = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        // Read strobe and address held a second cycle so both registered
        // and read-gated memories present valid data by the end of WAIT.
        mem_read    = 1'b1;
        mem_address = addr_q;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= PORT_DATA;
      port_q     <= PORT_FETCH;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rsp_vld_q  <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state     <= state_nxt;
      rsp_vld_q <= done;
      if (hs) begin
        port_q     <= win_port;
        last_grant <= win_port;
        wr_q       <= (win_port == PORT_DATA) ? req1_write : req0_write;
        addr_q     <= (win_port == PORT_DATA) ? req1_addr  : req0_addr;
        wdata_q    <= (win_port == PORT_DATA) ? req1_wdata : req0_wdata;
      end
      // Per-port data register only moves on that port's own response.
      if (done) begin
        if (port_q == PORT_FETCH) rdata0_q <= wr_q ? '0 : mem_data_out;
        else                      rdata1_q <= wr_q ? '0 : mem_data_out;
      end
    end
  end

  // port_q is only overwritten at the edge ending the pulse cycle, so a
  // back-to-back handshake cannot redirect the current pulse.
  assign rsp0_valid = rsp_vld_q && (port_q == PORT_FETCH);
  assign rsp1_valid = rsp_vld_q && (port_q == PORT_DATA);
  assign rsp0_rdata = rdata0_q;
  assign rsp1_rdata = rdata1_q;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  localparam int WIDTH = 4;
  localparam int DW    = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic            req0_valid, req0_ready, req0_write;
  logic [WIDTH-1:0] req0_addr;
  logic [DW-1:0]   req0_wdata;
  logic            rsp0_valid;
  logic [DW-1:0]   rsp0_rdata;
  logic            req1_valid, req1_ready, req1_write;
  logic [WIDTH-1:0] req1_addr;
  logic [DW-1:0]   req1_wdata;
  logic            rsp1_valid;
  logic [DW-1:0]   rsp1_rdata;
  logic            mem_write, mem_read, busy;
  logic [WIDTH-1:0] mem_address;
  logic [DW-1:0]   mem_data_in;
  logic [DW-1:0]   mem_data_out;

  mem_arbiter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .mem_write(mem_write), .mem_read(mem_read), .mem_address(mem_address),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .busy(busy)
  );

  always #5 clk = ~clk;

  // Registered-read single-port memory.
  logic [DW-1:0] mem [16];
  always @(posedge clk) begin
    if (mem_write) mem[mem_address] <= mem_data_in;
    if (mem_read)  mem_data_out <= mem[mem_address];
  end

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t          q0[$], q1[$];
  int            grants[$];
  logic [DW-1:0] ref_mem [16];
  int            cyc = 0;
  int            n_checks = 0, n_errors = 0;
  int            rsp_cnt0 = 0, rsp_cnt1 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void note_hs(input int p, input logic wr,
                                  input logic [WIDTH-1:0] a, input logic [DW-1:0] d);
    exp_t e;
    e.data = wr ? '0 : ref_mem[a];
    e.cyc  = cyc + (wr ? 2 : 3);
    if (wr) ref_mem[a] = d;
    if (p == 0) q0.push_back(e); else q1.push_back(e);
    grants.push_back(p);
  endfunction

  // Scoreboard monitor: responses popped/compared, handshakes pushed.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      n_checks++;
      if (mem_read && mem_write) begin
        n_errors++;
        $display("FAIL strobe_excl: mem_read=%b mem_write=%b both high", mem_read, mem_write);
      end
      if (rsp0_valid) begin
        rsp_cnt0++;
        n_checks++;
        if (q0.size() == 0) begin
          n_errors++;
          $display("FAIL rsp0_unexpected: got pulse rdata=%h, none expected", rsp0_rdata);
        end else begin
          e = q0.pop_front();
          if (rsp0_rdata !== e.data || cyc !== e.cyc) begin
            n_errors++;
            $display("FAIL rsp0: got data=%h cyc=%0d, expected data=%h cyc=%0d",
                     rsp0_rdata, cyc, e.data, e.cyc);
          end
        end
      end
      if (rsp1_valid) begin
        rsp_cnt1++;
        n_checks++;
        if (q1.size() == 0) begin
          n_errors++;
          $display("FAIL rsp1_unexpected: got pulse rdata=%h, none expected", rsp1_rdata);
        end else begin
          e = q1.pop_front();
          if (rsp1_rdata !== e.data || cyc !== e.cyc) begin
            n_errors++;
            $display("FAIL rsp1: got data=%h cyc=%0d, expected data=%h cyc=%0d",
                     rsp1_rdata, cyc, e.data, e.cyc);
          end
        end
      end
      if (req0_valid && req0_ready) note_hs(0, req0_write, req0_addr, req0_wdata);
      if (req1_valid && req1_ready) note_hs(1, req1_write, req1_addr, req1_wdata);
    end
  end

  // Present a request and wait for its handshake edge; valid is left high.
  task automatic req(input int p, input logic wr, input logic [WIDTH-1:0] a,
                     input logic [DW-1:0] d);
    int n = 0;
    logic rdy;
    if (p == 0) begin
      req0_write = wr; req0_addr = a; req0_wdata = d; req0_valid = 1'b1;
    end else begin
      req1_write = wr; req1_addr = a; req1_wdata = d; req1_valid = 1'b1;
    end
    do begin
      @(negedge clk);
      n++;
      rdy = (p == 0) ? req0_ready : req1_ready;
    end while (!rdy && n < 40);
    if (!rdy) begin
      n_checks++;
      n_errors++;
      $display("FAIL ready_timeout: port %0d ready=0, required 1 within 40 cycles", p);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    if (q0.size() != 0 || q1.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL rsp_timeout: pending q0=%0d q1=%0d, required 0", q0.size(), q1.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [51:0] outs;
    reset = 1'b1;
    #12;
    outs = {req0_ready, req1_ready, rsp0_valid, rsp1_valid, mem_write, mem_read, busy,
            mem_address, mem_data_in, rsp0_rdata, rsp1_rdata, 17'd0};
    n_checks++;
    if (outs !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: got %h, required 0", outs);
    end
    apply_reset();
  endtask

  task automatic test_write_read();
    req(0, 1'b1, 4'd0, 8'hAA); req0_valid = 1'b0;
    drain();
    req(0, 1'b0, 4'd0, 8'h00); req0_valid = 1'b0;
    drain();
    n_checks++;
    if (rsp0_rdata !== 8'hAA) begin
      n_errors++;
      $display("FAIL wr_rd_data: got %h, required aa", rsp0_rdata);
    end
  endtask

  task automatic test_tie_after_reset();
    apply_reset();
    grants.delete();
    fork
      begin req(0, 1'b1, 4'd1, 8'h55); req0_valid = 1'b0; end
      begin req(1, 1'b0, 4'd1, 8'h00); req1_valid = 1'b0; end
    join
    drain();
    n_checks++;
    if (grants.size() != 2 || grants[0] != 0 || grants[1] != 1) begin
      n_errors++;
      $display("FAIL tie_order: got %0d grants first=%0d, required 2 grants first=0",
               grants.size(), (grants.size() > 0) ? grants[0] : -1);
    end
    n_checks++;
    if (rsp1_rdata !== 8'h55) begin
      n_errors++;
      $display("FAIL tie_data: rsp1_rdata=%h, required 55", rsp1_rdata);
    end
  endtask

  task automatic test_back_to_back();
    grants.delete();
    rsp_cnt0 = 0;
    rsp_cnt1 = 0;
    fork
      begin for (int i = 0; i < 4; i++) req(0, 1'b0, 4'd0, 8'h00); req0_valid = 1'b0; end
      begin for (int j = 0; j < 4; j++) req(1, 1'b0, 4'd1, 8'h00); req1_valid = 1'b0; end
    join
    drain();
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (k >= grants.size() || grants[k] != (k % 2)) begin
        n_errors++;
        $display("FAIL rr_alternate[%0d]: got %0d, required %0d", k,
                 (k < grants.size()) ? grants[k] : -1, k % 2);
      end
    end
    n_checks++;
    if (rsp_cnt0 != 4 || rsp_cnt1 != 4) begin
      n_errors++;
      $display("FAIL rr_counts: got %0d/%0d pulses, required 4/4", rsp_cnt0, rsp_cnt1);
    end
  endtask

  task automatic test_top_addr();
    req(1, 1'b0, 4'd15, 8'h00);
    req(1, 1'b1, 4'd15, 8'h3C);
    req(1, 1'b0, 4'd15, 8'h00);
    req1_valid = 1'b0;
    drain();
    n_checks++;
    if (rsp1_rdata !== 8'h3C || mem[0] !== 8'hAA) begin
      n_errors++;
      $display("FAIL top_addr: rsp1_rdata=%h mem0=%h, required 3c / aa", rsp1_rdata, mem[0]);
    end
  endtask

  task automatic test_reset_mid_read();
    logic [51:0] outs;
    req(1, 1'b0, 4'd1, 8'h00);
    req1_valid = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (!(busy === 1'b1 && mem_read === 1'b1)) begin
      n_errors++;
      $display("FAIL in_wait: busy=%b mem_read=%b, required 1/1", busy, mem_read);
    end
    reset = 1'b1;
    #1;
    outs = {req0_ready, req1_ready, rsp0_valid, rsp1_valid, mem_write, mem_read, busy,
            mem_address, mem_data_in, rsp0_rdata, rsp1_rdata, 17'd0};
    n_checks++;
    if (outs !== '0) begin
      n_errors++;
      $display("FAIL reset_async: got %h, required 0", outs);
    end
    q1.delete();
    grants.delete();
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    req(1, 1'b0, 4'd1, 8'h00);
    req1_valid = 1'b0;
    drain();
    n_checks++;
    if (rsp1_rdata !== 8'h55) begin
      n_errors++;
      $display("FAIL post_reset_read: got %h, required 55", rsp1_rdata);
    end
  endtask

`ifdef MEM_ARB_FIXED_PRIO_EN
  task automatic test_fixed_prio();
    grants.delete();
    fork
      begin for (int i = 0; i < 3; i++) req(0, 1'b0, 4'd0, 8'h00); req0_valid = 1'b0; end
      begin req(1, 1'b0, 4'd1, 8'h00); req1_valid = 1'b0; end
    join
    drain();
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (k >= grants.size() || grants[k] != ((k == 3) ? 1 : 0)) begin
        n_errors++;
        $display("FAIL fixed_prio[%0d]: got %0d, required %0d", k,
                 (k < grants.size()) ? grants[k] : -1, (k == 3) ? 1 : 0);
      end
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    req0_valid = 1'b0; req0_write = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_write = 1'b0; req1_addr = '0; req1_wdata = '0;
    mem_data_out = '0;
    for (int i = 0; i < 16; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    test_reset();
    test_write_read();
    test_tie_after_reset();
    test_back_to_back();
    test_top_addr();
    test_reset_mid_read();
`ifdef MEM_ARB_FIXED_PRIO_EN
    test_fixed_prio();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the CPU's single-port `memory` block (WIDTH address bits, 2*WIDTH data bits).
- Port 0 is the instruction-fetch side and port 1 is the load/store side.
- Serialises requests with a valid/ready handshake, drives the memory's write/read/address/data_in strobes, and returns read data or a write acknowledge to the winning requester.

Parameters:
WIDTH, 4, memory address width; data width is 2*WIDTH.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
req0_valid  input  1  port 0 request valid
req0_ready  output  1  port 0 request accepted this cycle
req0_write  input  1  port 0: 1=write, 0=read
req0_addr  input  WIDTH  port 0 address
req0_wdata  input  2*WIDTH  port 0 write data
rsp0_valid  output  1  port 0 response pulse
rsp0_rdata  output  2*WIDTH  port 0 read data (0 for write ack)
req1_valid, req1_ready, req1_write, req1_addr, req1_wdata, rsp1_valid, rsp1_rdata  same as port 0, for port 1
mem_write  output  1  memory write strobe
mem_read  output  1  memory read strobe
mem_address  output  WIDTH  memory address
mem_data_in  output  2*WIDTH  memory write data
mem_data_out  input  2*WIDTH  memory read data
busy  output  1  high whenever state != IDLE

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high.
- Reset values: all outputs 0; state=IDLE; last_grant=1, so port 0 wins the first tie.
- FSM states: IDLE, ACCESS, WAIT.
- IDLE:
  - Grant is combinational from req0_valid, req1_valid and last_grant (round-robin).
  - reqN_ready=1 only for the granted port, only in IDLE, only while its valid is high.
  - A handshake is valid&ready at a rising edge. On it: latch port id, write, addr and wdata; set last_grant; go to ACCESS.
- ACCESS (1 cycle):
  - mem_address and mem_data_in come from latched registers.
  - Write: mem_write=1 and mem_read=0; next state IDLE.
  - Read: mem_read=1; next state WAIT.
- WAIT (1 cycle):
  - mem_read stays 1 and mem_address is held stable, so both registered and read-gated memories work.
  - mem_data_out is captured into rdata_q at the end of WAIT.
  - Next state IDLE.
- Response:
  - rsp_valid for the latched port is a registered one-cycle pulse in the first IDLE cycle after the transaction.
  - rspN_rdata=rdata_q for reads and 0 for writes.
  - rdata holds its value until the next response on that port.
- Latency, counting from the handshake edge (cycle 0):
  - Write: committed at end of cycle 1; rsp_valid in cycle 2.
  - Read: rsp_valid in cycle 3.
- Back-to-back: a new handshake may occur in the same IDLE cycle that carries a rsp_valid pulse.
- Throughput: a write issues every 2 cycles; a read every 3 cycles.
- Both requests valid: the port other than last_grant wins; the loser keeps valid high and wins next.
- Only one request valid: that port wins regardless of last_grant.
- Requester rules:
  - Payload must stay stable while valid is high and ready is low.
  - Dropping valid before ready is legal; the request is simply withdrawn.
- mem_write and mem_read are never both 1; both are 0 in IDLE.
- Reset mid-operation:
  - All strobes drop immediately and the transaction is aborted.
  - No rsp_valid is issued, and last_grant returns to 1.
  - A write interrupted in ACCESS is not guaranteed committed.
- Address wraps naturally within WIDTH bits; there is no range check.

Optional Feature:
- Macro: MEM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; port 0 always wins when both ports are valid. last_grant is unused, and port 1 can starve.
- Undefined: round-robin as specified in Behaviour.

Decomposition:
- Package mem_arb_pkg holds:
  - the state enum (IDLE, ACCESS, WAIT);
  - typedef port_id_t (1 bit);
  - constants PORT_FETCH=0 and PORT_DATA=1.
- Sub-module rr_arbiter2 is combinational grant logic: inputs req[1:0], last_grant, enable; output one-hot gnt[1:0].
  - The MEM_ARB_FIXED_PRIO_EN switch lives inside rr_arbiter2.

Test Plan (WIDTH=4, mem_arbiter connected to memory):
1. Port 0 writes 0xAA to addr 0, then reads addr 0.
   - rsp0_valid 2 cycles after the write handshake.
   - rsp0_valid 3 cycles after the read handshake, with rsp0_rdata=0xAA.
2. Port 0 (write 0x55 to addr 1) and port 1 (read addr 1) both assert valid in the same cycle after reset.
   - Port 0 wins first.
   - Port 1 is then served and gets rsp1_rdata=0x55.
3. Both ports keep valid high continuously, issuing 4 reads each to addr 0 and addr 1.
   - Grants alternate 0,1,0,1...
   - Each port receives exactly 4 rsp_valid pulses with the correct data.
   - mem_read and mem_write are never both 1.
4. Read of addr 15, then write 0x3C to addr 15, then read addr 15.
   - Returns 0x3C; the top address is exercised with no wrap artefacts.
5. Assert reset during WAIT of a read to addr 1.
   - All outputs go to 0 asynchronously; no rsp_valid.
   - A post-reset read of addr 1 completes normally.
6. With MEM_ARB_FIXED_PRIO_EN defined, both ports keep valid high.
   - Port 0 is granted every time; port 1 gets ready only after req0_valid drops.
